// File: rtl/pmp_dmp_pkg.sv
// rtl/pmp_dmp_pkg.sv - shared types, cfg encodings and domain helpers for the PMP+DMP scan checker
package pmp_dmp_pkg;

    localparam int unsigned DOM_W = 2;

    typedef logic [DOM_W-1:0] dom_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    // Privilege encoding of machine mode
    localparam logic [1:0] PRIV_M = 2'b11;

    // pmpcfg.A address-matching modes
    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    // All-ones domain id is the wildcard (DOMI)
    function automatic logic dom_wildcard(input dom_t d);
        return d == {DOM_W{1'b1}};
    endfunction

    // An entry admits a domain when ids agree or either side is the wildcard
    function automatic logic dom_allow(input dom_t entry_dom, input dom_t cur_dom);
        return (entry_dom == cur_dom) || dom_wildcard(entry_dom) || dom_wildcard(cur_dom);
    endfunction

endpackage

// File: rtl/pmp_dmp_scan_checker_if.sv
// rtl/pmp_dmp_scan_checker_if.sv - request/response/fault signal bundle of the scan checker
interface pmp_dmp_scan_checker_if #(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned DOM_W      = 2
);
    localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [PLEN-1:0]  req_addr_i;
    logic [2:0]       req_access_i;
    logic [1:0]       req_priv_i;
    logic [DOM_W-1:0] req_dom_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_allow_o;
    logic             rsp_match_o;
    logic [IDX_W-1:0] rsp_idx_o;
    logic             fault_valid_o;
    logic [PLEN-1:0]  fault_addr_o;
    logic [DOM_W-1:0] fault_dom_o;
    logic             fault_clear_i;

    modport master (
        output flush_i, req_valid_i, req_addr_i, req_access_i, req_priv_i, req_dom_i,
               rsp_ready_i, fault_clear_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_match_o, rsp_idx_o,
               fault_valid_o, fault_addr_o, fault_dom_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_addr_i, req_access_i, req_priv_i, req_dom_i,
               rsp_ready_i, fault_clear_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_match_o, rsp_idx_o,
               fault_valid_o, fault_addr_o, fault_dom_o
    );

endinterface

// File: rtl/pmp_dmp_entry.sv
// rtl/pmp_dmp_entry.sv - combinational single-entry address match with PMP and DMP rights
module pmp_dmp_entry
    import pmp_dmp_pkg::*;
#(
    parameter int unsigned PMP_LEN = 32
) (
    input  logic [PMP_LEN-1:0] word_addr,
    input  logic [2:0]         access,
    input  logic               is_m,
    input  dom_t               dom,
    input  logic               lock,
    input  logic [1:0]         mode,
    input  logic [2:0]         rwx,
    input  logic [PMP_LEN-1:0] pmp_addr,
    input  logic [PMP_LEN-1:0] lo_addr,
    input  dom_t               entry_dom,
    output logic               match,
    output logic               allow
);

    logic [PMP_LEN-1:0] napot_mask;
    logic               pmp_pass;

    // Adding one flips the trailing ones and the first zero; those bits are don't-care in NAPOT
    assign napot_mask = ~(pmp_addr ^ (pmp_addr + PMP_LEN'(1)));

    // Address match by mode; addresses compared in 4-byte word units
    always_comb begin
        match = 1'b0;
        case (mode)
            A_TOR:   match = (word_addr >= lo_addr) && (word_addr < pmp_addr);
            A_NA4:   match = (word_addr == pmp_addr);
            A_NAPOT: match = ((word_addr ^ pmp_addr) & napot_mask) == '0;
            default: match = 1'b0;
        endcase
    end

    // Unlocked entries do not restrict M-mode; otherwise the requested right must be granted
    assign pmp_pass = (is_m && !lock) ? 1'b1 : ((access & rwx) == access);
    assign allow    = pmp_pass && dom_allow(entry_dom, dom);

endmodule

// File: rtl/pmp_dmp_scan_checker.sv
// rtl/pmp_dmp_scan_checker.sv - chunked PMP+DMP scan checker; optional PMP_DMP_FAULT_CAPTURE_EN first-fault capture
module pmp_dmp_scan_checker #(
    parameter int unsigned PLEN              = 34,
    parameter int unsigned PMP_LEN           = 32,
    parameter int unsigned NR_ENTRIES        = 16,
    parameter int unsigned ENTRIES_PER_CYCLE = 4,
    parameter int unsigned DOM_W             = pmp_dmp_pkg::DOM_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pmp_dmp_scan_checker_if.slave         bus,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*8-1:0]       pmpconf_i,
    input  logic [NR_ENTRIES*DOM_W-1:0]   dmpconf_i
);
    import pmp_dmp_pkg::*;

    localparam int unsigned EPC        = ENTRIES_PER_CYCLE;
    localparam int unsigned NR_CHUNKS  = NR_ENTRIES / EPC;
    localparam int unsigned CW         = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;
    localparam int unsigned IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NR_CHUNKS - 1);

    state_t             state;
    logic [CW-1:0]      chunk;
    logic [PLEN-1:0]    lat_addr;
    logic [2:0]         lat_access;
    logic [1:0]         lat_priv;
    dom_t               lat_dom;
    logic               rsp_valid;
    logic               rsp_allow;
    logic               rsp_match;
    logic [IDX_W-1:0]   rsp_idx;

    logic [PMP_LEN-1:0] addr_arr [NR_ENTRIES];
    logic               lock_arr [NR_ENTRIES];
    logic [1:0]         mode_arr [NR_ENTRIES];
    logic [2:0]         rwx_arr  [NR_ENTRIES];
    dom_t               dom_arr  [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] unused_rsvd;

    logic               ent_match [EPC];
    logic               ent_allow [EPC];
    logic [IDX_W-1:0]   ent_idx   [EPC];

    logic               is_m;
    logic               hit;
    logic               hit_allow;
    logic [IDX_W-1:0]   hit_idx;
    logic               scan_done;
    logic               done_allow;

    for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_unpack
        assign addr_arr[e]    = conf_addr_i[e*PMP_LEN +: PMP_LEN];
        assign lock_arr[e]    = pmpconf_i[e*8 + 7];
        assign mode_arr[e]    = pmpconf_i[e*8 + 3 +: 2];
        assign rwx_arr[e]     = pmpconf_i[e*8 +: 3];
        assign dom_arr[e]     = dmpconf_i[e*DOM_W +: DOM_W];
        assign unused_rsvd[e] = ^pmpconf_i[e*8 + 5 +: 2];
    end

    assign is_m = (lat_priv == PRIV_M);

    for (genvar j = 0; j < EPC; j++) begin : g_ent
        logic [IDX_W-1:0]   idx;
        logic [PMP_LEN-1:0] lo;

        assign idx        = IDX_W'(32'(chunk) * EPC + j);
        assign lo         = (idx == '0) ? '0 : addr_arr[idx - IDX_W'(1)];
        assign ent_idx[j] = idx;

        pmp_dmp_entry #(
            .PMP_LEN (PMP_LEN)
        ) u_entry (
            .word_addr (lat_addr[PLEN-1:2]),
            .access    (lat_access),
            .is_m      (is_m),
            .dom       (lat_dom),
            .lock      (lock_arr[idx]),
            .mode      (mode_arr[idx]),
            .rwx       (rwx_arr[idx]),
            .pmp_addr  (addr_arr[idx]),
            .lo_addr   (lo),
            .entry_dom (dom_arr[idx]),
            .match     (ent_match[j]),
            .allow     (ent_allow[j])
        );
    end

    // Lowest matching entry of the current chunk wins
    always_comb begin
        hit       = 1'b0;
        hit_allow = 1'b0;
        hit_idx   = '0;
        for (int j = EPC - 1; j >= 0; j--) begin
            if (ent_match[j]) begin
                hit       = 1'b1;
                hit_allow = ent_allow[j];
                hit_idx   = ent_idx[j];
            end
        end
    end

    assign scan_done  = (state == SCAN) && !bus.flush_i && (hit || (chunk == LAST_CHUNK));
    assign done_allow = hit ? hit_allow : is_m;

    // Request/scan/response sequencing with registered response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            chunk      <= '0;
            lat_addr   <= '0;
            lat_access <= '0;
            lat_priv   <= '0;
            lat_dom    <= '0;
            rsp_valid  <= 1'b0;
            rsp_allow  <= 1'b0;
            rsp_match  <= 1'b0;
            rsp_idx    <= '0;
        end else if (bus.flush_i) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        lat_addr   <= bus.req_addr_i;
                        lat_access <= bus.req_access_i;
                        lat_priv   <= bus.req_priv_i;
                        lat_dom    <= bus.req_dom_i;
                        chunk      <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_allow <= done_allow;
                        rsp_match <= hit;
                        rsp_idx   <= hit ? hit_idx : '0;
                    end else begin
                        chunk <= chunk + CW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (state == IDLE);
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_allow_o = rsp_allow;
    assign bus.rsp_match_o = rsp_match;
    assign bus.rsp_idx_o   = rsp_idx;

`ifdef PMP_DMP_FAULT_CAPTURE_EN
    logic            fault_valid;
    logic [PLEN-1:0] fault_addr;
    dom_t            fault_dom;

    // Sticky first-denial capture; a denial coinciding with a clear is kept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_dom   <= '0;
        end else begin
            if (bus.fault_clear_i) begin
                fault_valid <= 1'b0;
            end
            if (scan_done && !done_allow && (!fault_valid || bus.fault_clear_i)) begin
                fault_valid <= 1'b1;
                fault_addr  <= lat_addr;
                fault_dom   <= lat_dom;
            end
        end
    end

    assign bus.fault_valid_o = fault_valid;
    assign bus.fault_addr_o  = fault_addr;
    assign bus.fault_dom_o   = fault_dom;
`else
    logic unused_fault_clear;

    assign unused_fault_clear = bus.fault_clear_i;
    assign bus.fault_valid_o  = 1'b0;
    assign bus.fault_addr_o   = '0;
    assign bus.fault_dom_o    = '0;
`endif

endmodule
